// File: rtl/if_stage_pkg.sv
// Shared processor package for the fetch stage: word width, bubble encoding,
// fetch FSM state type, IF/ID record and address alignment helper.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  // Instruction word inserted into IF/ID when it carries a bubble.
  localparam logic [XLEN-1:0] NOP_INST = 32'd0;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect/stall controls from the
// rest of the pipeline, and the IF/ID register outputs toward decode.
interface if_stage_if;
  import if_stage_pkg::*;

  logic            freeze;
  logic            branch_taken;
  logic [XLEN-1:0] branch_addr;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] pc_id;
  logic [XLEN-1:0] instruction_id;
  logic            valid_id;

  // Fetch stage side.
  modport master (
    input  freeze, branch_taken, branch_addr, inst_data,
    output inst_pc, pc_id, instruction_id, valid_id
  );

  // Pipeline / memory side.
  modport slave (
    output freeze, branch_taken, branch_addr, inst_data,
    input  inst_pc, pc_id, instruction_id, valid_id
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with clear (bubble), hold and load controls.
// Priority: rst/clear > hold > load; with none asserted the contents stay put.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out
);

  if_id_t q;

  // Register update: bubble on reset/clear, otherwise hold or capture.
  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '{pc: '0, instr: NOP_INST, valid: 1'b0};
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= '{pc: pc_in, instr: instr_in, valid: 1'b1};
    end
  end

  assign pc_out    = q.pc;
  assign instr_out = q.instr;
  assign valid_out = q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, boot/run/hold FSM and the IF/ID
// register. Per edge: branch_taken > freeze > sequential advance; rst wins
// over everything. Optional performance counters (fetch_count, stall_count)
// are built only when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'd0,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  if_stage_if.master      bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
`endif
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_next_seq;
  logic            ifid_load, ifid_clear, ifid_hold;

  assign pc_next_seq = pc_q + PC_STEP;  // wraps modulo 2^32
  assign bus.inst_pc = pc_q;

  // State and PC registers; synchronous reset back to the boot state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-PC and IF/ID control selection.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    ifid_hold  = 1'b0;
    if (bus.branch_taken) begin
      pc_d       = align_word(bus.branch_addr);
      ifid_clear = 1'b1;
      state_d    = S_RUN;
    end else if (bus.freeze) begin
      ifid_hold  = 1'b1;
      state_d    = S_HOLD;
    end else begin
      pc_d       = pc_next_seq;
      ifid_load  = 1'b1;
      state_d    = S_RUN;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .clear     (ifid_clear),
    .hold      (ifid_hold),
    .pc_in     (pc_next_seq),
    .instr_in  (bus.inst_data),
    .pc_out    (bus.pc_id),
    .instr_out (bus.instruction_id),
    .valid_out (bus.valid_id)
  );

`ifdef IF_PERF_CNT_EN
  // Count sequential fetches and stall cycles; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ifid_load) fetch_count <= fetch_count + 32'd1;
      if (ifid_hold) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed table, hand-written multi-cycle
// sequences, then randomized stimulus against a behavioural fetch model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'd0;
  localparam logic [31:0] STEP   = 32'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  if_stage #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // Instruction memory: a fixed scrambling of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign bus.inst_data = mem_word(bus.inst_pc);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of the architectural fetch state.
  logic [31:0] m_pc = RST_PC, m_pc_id = 32'd0, m_instr = 32'd0;
  logic        m_valid = 1'b0;
  if_state_t   m_state = S_BOOT;
  logic [31:0] m_fetch = 32'd0, m_stall = 32'd0;

  task automatic model_update(input logic r, input logic f, input logic b, input logic [31:0] a);
    if (r) begin
      m_pc = RST_PC; m_pc_id = 0; m_instr = 0; m_valid = 0; m_state = S_BOOT;
      m_fetch = 0; m_stall = 0;
    end else if (b) begin
      m_pc = a - (a % 4); m_pc_id = 0; m_instr = 0; m_valid = 0; m_state = S_RUN;
    end else if (f) begin
      m_state = S_HOLD; m_stall = m_stall + 1;
    end else begin
      m_instr = mem_word(m_pc); m_pc = m_pc + STEP; m_pc_id = m_pc; m_valid = 1;
      m_state = S_RUN; m_fetch = m_fetch + 1;
    end
  endtask

  // Apply one cycle of inputs; outputs are settled #1 after the edge.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
    @(negedge clk);
    rst = r; bus.freeze = f; bus.branch_taken = b; bus.branch_addr = a;
    @(posedge clk);
    model_update(r, f, b, a);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " inst_pc"}, bus.inst_pc, m_pc);
    check({tag, " pc_id"}, bus.pc_id, m_pc_id);
    check({tag, " instruction_id"}, bus.instruction_id, m_instr);
    check({tag, " valid_id"}, 32'(bus.valid_id), 32'(m_valid));
    check({tag, " state"}, 32'(dut.state_q), 32'(m_state));
`ifdef IF_PERF_CNT_EN
    check({tag, " fetch_count"}, fetch_count, m_fetch);
    check({tag, " stall_count"}, stall_count, m_stall);
`endif
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc_id,
                           input logic e_valid, input logic [31:0] e_instr, input if_state_t e_state);
    check({tag, " inst_pc"}, bus.inst_pc, e_pc);
    check({tag, " pc_id"}, bus.pc_id, e_pc_id);
    check({tag, " valid_id"}, 32'(bus.valid_id), 32'(e_valid));
    check({tag, " instruction_id"}, bus.instruction_id, e_instr);
    check({tag, " state"}, 32'(dut.state_q), 32'(e_state));
  endtask

  typedef struct {
    logic        r, f, b;
    logic [31:0] a;
    logic [31:0] e_pc, e_pc_id;
    logic        e_valid;
    if_state_t   e_state;
    logic [31:0] e_fetch, e_stall;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] a,
                              input logic [31:0] e_pc, input logic [31:0] e_pc_id, input logic e_valid,
                              input if_state_t e_state, input logic [31:0] e_fetch, input logic [31:0] e_stall);
    vec_t v;
    v.r = r; v.f = f; v.b = b; v.a = a; v.e_pc = e_pc; v.e_pc_id = e_pc_id; v.e_valid = e_valid;
    v.e_state = e_state; v.e_fetch = e_fetch; v.e_stall = e_stall;
    return v;
  endfunction

  vec_t vt[18];

  initial begin
    logic r, f, b;
    logic [31:0] a;
    string tag;

    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'd0;

    //         rst   frz   br    addr           pc             pc_id          v     state   fch    stl
    vt[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0,         1'b0, S_BOOT, 32'd0, 32'd0);
    vt[1]  = mk(1'b1, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0,         1'b0, S_BOOT, 32'd0, 32'd0);
    vt[2]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd4,         32'd4,         1'b1, S_RUN,  32'd1, 32'd0);
    vt[3]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd8,         32'd8,         1'b1, S_RUN,  32'd2, 32'd0);
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd12,        32'd12,        1'b1, S_RUN,  32'd3, 32'd0);
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd16,        32'd16,        1'b1, S_RUN,  32'd4, 32'd0);
    vt[6]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'd16,        32'd16,        1'b1, S_HOLD, 32'd4, 32'd1);
    vt[7]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'd16,        32'd16,        1'b1, S_HOLD, 32'd4, 32'd2);
    vt[8]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'd16,        32'd16,        1'b1, S_HOLD, 32'd4, 32'd3);
    vt[9]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd20,        32'd20,        1'b1, S_RUN,  32'd5, 32'd3);
    vt[10] = mk(1'b0, 1'b0, 1'b1, 32'd144,       32'd144,       32'd0,         1'b0, S_RUN,  32'd5, 32'd3);
    vt[11] = mk(1'b0, 1'b0, 1'b1, 32'd112,       32'd112,       32'd0,         1'b0, S_RUN,  32'd5, 32'd3);
    vt[12] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd116,       32'd116,       1'b1, S_RUN,  32'd6, 32'd3);
    vt[13] = mk(1'b0, 1'b1, 1'b1, 32'h3E,        32'h3C,        32'd0,         1'b0, S_RUN,  32'd6, 32'd3);
    vt[14] = mk(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFC,  32'd0,         1'b0, S_RUN,  32'd6, 32'd3);
    vt[15] = mk(1'b0, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0,         1'b1, S_RUN,  32'd7, 32'd3);
    vt[16] = mk(1'b0, 1'b1, 1'b0, 32'd0,         32'd0,         32'd0,         1'b1, S_HOLD, 32'd7, 32'd4);
    vt[17] = mk(1'b1, 1'b1, 1'b0, 32'd0,         32'd0,         32'd0,         1'b0, S_BOOT, 32'd0, 32'd0);

    // Reset-state sample before any edge releases reset.
    @(posedge clk); #1;
    check("initial inst_pc", bus.inst_pc, RST_PC);
    check("initial valid_id", 32'(bus.valid_id), 32'd0);

    // Directed table: the instruction expected in IF/ID is the word fetched
    // from pc_id - STEP (its fetch address), or the bubble word.
    for (int i = 0; i < 18; i++) begin
      logic [31:0] e_instr;
      step(vt[i].r, vt[i].f, vt[i].b, vt[i].a);
      e_instr = vt[i].e_valid ? mem_word(vt[i].e_pc_id - STEP) : NOP_INST;
      tag = $sformatf("row%0d", i);
      check_out(tag, vt[i].e_pc, vt[i].e_pc_id, vt[i].e_valid, e_instr, vt[i].e_state);
`ifdef IF_PERF_CNT_EN
      check({tag, " fetch_count"}, fetch_count, vt[i].e_fetch);
      check({tag, " stall_count"}, stall_count, vt[i].e_stall);
`endif
    end

    // Back-to-back redirects: last target wins, then one clean fetch.
    step(1'b0, 1'b0, 1'b1, 32'h200);
    check_out("b2b first", 32'h200, 32'd0, 1'b0, NOP_INST, S_RUN);
    step(1'b0, 1'b0, 1'b1, 32'h301);
    check_out("b2b second", 32'h300, 32'd0, 1'b0, NOP_INST, S_RUN);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_out("b2b advance", 32'h304, 32'h304, 1'b1, mem_word(32'h300), S_RUN);

    // Stall release captures the held word exactly once.
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_out("stall pre", 32'h308, 32'h308, 1'b1, mem_word(32'h304), S_RUN);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_out("stall held", 32'h308, 32'h308, 1'b1, mem_word(32'h304), S_HOLD);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_out("stall release", 32'h30C, 32'h30C, 1'b1, mem_word(32'h308), S_RUN);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_out("stall after", 32'h310, 32'h310, 1'b1, mem_word(32'h30C), S_RUN);

    // Reset beats a simultaneous redirect; freeze straight out of boot.
    step(1'b1, 1'b0, 1'b1, 32'h500);
    check_out("rst over branch", RST_PC, 32'd0, 1'b0, NOP_INST, S_BOOT);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_out("boot freeze", RST_PC, 32'd0, 1'b0, NOP_INST, S_HOLD);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_out("boot release", RST_PC + STEP, RST_PC + STEP, 1'b1, mem_word(RST_PC), S_RUN);
    check_model("model sync");

    // Randomized stimulus against the behavioural model.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      b = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 3) == 0);
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFF8 | (a & 32'h7);
      step(r, f, b, a);
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
